// File: rtl/lc3_intc_pkg.sv
// Shared types and constants for the LC-3 interrupt controller.
// The optional exception path is enabled with the LC3_INTC_EXC_EN macro.
package lc3_intc_pkg;

    localparam int         PSR_PRIO_W    = 3;
    localparam logic [7:0] INTC_VEC_PRIV = 8'h00;
    localparam logic [7:0] INTC_VEC_ILL  = 8'h01;

    typedef enum logic [1:0] {
        INTC_IDLE,
        INTC_REQ,
        INTC_RECOV
    } IntcState_t;

    // Which kind of event the latched request belongs to, so the ack clears the right sticky bit.
    typedef enum logic [1:0] {
        WIN_IRQ,
        WIN_PRIV,
        WIN_ILL
    } win_src_t;

endpackage

// File: rtl/lc3_intc_arb.sv
// Combinational priority arbiter: highest priority wins, ties go to the lowest index.
// Built as a balanced compare tree over a power-of-two leaf layer.
module lc3_intc_arb
    import lc3_intc_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    parameter  int PRIO_W  = PSR_PRIO_W,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [PRIO_W-1:0]  prio [NUM_SRC],
    output logic               any,
    output logic [IDX_W-1:0]   win_idx,
    output logic [PRIO_W-1:0]  win_prio
);

    localparam int LEAVES = 1 << IDX_W;

    logic              node_v [2*LEAVES];
    logic [PRIO_W-1:0] node_p [2*LEAVES];
    logic [IDX_W-1:0]  node_i [2*LEAVES];

    // NOTE: blocking assignments with a full default first keep this purely combinational (no latches).
    always_comb begin
        for (int n = 0; n < 2*LEAVES; n++) begin
            node_v[n] = 1'b0;
            node_p[n] = '0;
            node_i[n] = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            if (i < NUM_SRC) begin
                node_v[LEAVES+i] = elig[i];
                node_p[LEAVES+i] = prio[i];
                node_i[LEAVES+i] = IDX_W'(i);
            end
        end
        // Left child holds the lower indices, so it keeps the win on equal priority.
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (node_v[2*n] && (!node_v[2*n+1] || node_p[2*n] >= node_p[2*n+1])) begin
                node_v[n] = 1'b1;
                node_p[n] = node_p[2*n];
                node_i[n] = node_i[2*n];
            end else begin
                node_v[n] = node_v[2*n+1];
                node_p[n] = node_p[2*n+1];
                node_i[n] = node_i[2*n+1];
            end
        end
        any      = node_v[1];
        win_idx  = node_i[1];
        win_prio = node_p[1];
    end

endmodule

// File: rtl/lc3_intc.sv
// LC-3 interrupt controller: latches device requests, arbitrates against PSR priority and
// holds one request stable until acked. Define LC3_INTC_EXC_EN to add privilege/illegal exceptions.
module lc3_intc
    import lc3_intc_pkg::*;
#(
    parameter  int         NUM_SRC  = 8,
    parameter  int         PRIO_W   = PSR_PRIO_W,
    parameter  logic [7:0] VEC_BASE = 8'h80,
    parameter  bit         EDGE     = 1'b1,
    localparam int         IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [PRIO_W-1:0]  cfg_prio,
    input  logic [PRIO_W-1:0]  cur_prio,
    input  logic               int_ack,
`ifdef LC3_INTC_EXC_EN
    input  logic               exc_priv,
    input  logic               exc_ill,
`endif
    output logic               int_req,
    output logic [7:0]         int_vec,
    output logic [PRIO_W-1:0]  int_prio,
    output logic [NUM_SRC-1:0] pend
);

    IntcState_t        state_q, state_d;
    win_src_t          win_src_q, win_src_d;
    logic [IDX_W-1:0]  win_idx_q, win_idx_d;
    logic [NUM_SRC-1:0] irq_q, pend_q, pend_d, en_q, en_d;
    logic [PRIO_W-1:0] prio_q [NUM_SRC];
    logic [PRIO_W-1:0] prio_d [NUM_SRC];
    logic              int_req_q, int_req_d;
    logic [7:0]        int_vec_q, int_vec_d;
    logic [PRIO_W-1:0] int_prio_q, int_prio_d;
    logic              exc_priv_q, exc_priv_d, exc_ill_q, exc_ill_d;

    logic [NUM_SRC-1:0] elig, clr;
    logic               arb_any, ack_take;
    logic [IDX_W-1:0]   arb_idx;
    logic [PRIO_W-1:0]  arb_prio;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > cur_prio);
        end
    end

    lc3_intc_arb #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_arb (
        .elig     (elig),
        .prio     (prio_q),
        .any      (arb_any),
        .win_idx  (arb_idx),
        .win_prio (arb_prio)
    );

    always_comb begin
        state_d    = state_q;
        win_src_d  = win_src_q;
        win_idx_d  = win_idx_q;
        en_d       = en_q;
        prio_d     = prio_q;
        int_req_d  = int_req_q;
        int_vec_d  = int_vec_q;
        int_prio_d = int_prio_q;
        ack_take   = (state_q == INTC_REQ) && int_ack;

        if (cfg_we && (int'(cfg_idx) < NUM_SRC)) begin
            en_d[cfg_idx]   = cfg_en;
            prio_d[cfg_idx] = cfg_prio;
        end

        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = ack_take && (win_src_q == WIN_IRQ) && (win_idx_q == IDX_W'(i));
        end
        // A fresh edge in the clearing cycle is ORed in last so it survives the ack.
        if (EDGE) pend_d = (pend_q & ~clr) | (irq & ~irq_q);
        else      pend_d = irq_q;

`ifdef LC3_INTC_EXC_EN
        exc_priv_d = (exc_priv_q & ~(ack_take && win_src_q == WIN_PRIV)) | exc_priv;
        exc_ill_d  = (exc_ill_q  & ~(ack_take && win_src_q == WIN_ILL))  | exc_ill;
`else
        exc_priv_d = 1'b0;
        exc_ill_d  = 1'b0;
`endif

        case (state_q)
            INTC_IDLE: begin
                if (exc_priv_q) begin
                    win_src_d  = WIN_PRIV;
                    int_vec_d  = INTC_VEC_PRIV;
                    int_prio_d = cur_prio;
                    int_req_d  = 1'b1;
                    state_d    = INTC_REQ;
                end else if (exc_ill_q) begin
                    win_src_d  = WIN_ILL;
                    int_vec_d  = INTC_VEC_ILL;
                    int_prio_d = cur_prio;
                    int_req_d  = 1'b1;
                    state_d    = INTC_REQ;
                end else if (arb_any) begin
                    win_src_d  = WIN_IRQ;
                    win_idx_d  = arb_idx;
                    int_vec_d  = VEC_BASE + 8'(arb_idx);
                    int_prio_d = arb_prio;
                    int_req_d  = 1'b1;
                    state_d    = INTC_REQ;
                end
            end
            INTC_REQ: begin
                if (int_ack) begin
                    int_req_d = 1'b0;
                    state_d   = INTC_RECOV;
                end
            end
            default: state_d = INTC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= INTC_IDLE;
            win_src_q  <= WIN_IRQ;
            win_idx_q  <= '0;
            irq_q      <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            int_req_q  <= 1'b0;
            int_vec_q  <= '0;
            int_prio_q <= '0;
            exc_priv_q <= 1'b0;
            exc_ill_q  <= 1'b0;
            // NOTE: the priority table is explicitly reset because a zero priority is what keeps an unconfigured source silent.
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            win_src_q  <= win_src_d;
            win_idx_q  <= win_idx_d;
            irq_q      <= irq;
            pend_q     <= pend_d;
            en_q       <= en_d;
            prio_q     <= prio_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            int_prio_q <= int_prio_d;
            exc_priv_q <= exc_priv_d;
            exc_ill_q  <= exc_ill_d;
        end
    end

    assign int_req  = int_req_q;
    assign int_vec  = int_vec_q;
    assign int_prio = int_prio_q;
    assign pend     = pend_q;

endmodule

// File: tb/tb_lc3_intc.sv
// Directed bench for lc3_intc: expected request vectors/priorities go to a scoreboard when
// stimulus is driven and are compared when int_req appears.
module tb_lc3_intc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irq = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic       cfg_en = 1'b0;
    logic [2:0] cfg_prio = '0;
    logic [2:0] cur_prio = '0;
    logic       int_ack = 1'b0;
`ifdef LC3_INTC_EXC_EN
    logic       exc_priv = 1'b0;
    logic       exc_ill = 1'b0;
`endif
    logic       int_req;
    logic [7:0] int_vec;
    logic [2:0] int_prio;
    logic [7:0] pend;

    typedef struct {
        logic [7:0] vec;
        logic [2:0] prio;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lc3_intc dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_en   (cfg_en),
        .cfg_prio (cfg_prio),
        .cur_prio (cur_prio),
        .int_ack  (int_ack),
`ifdef LC3_INTC_EXC_EN
        .exc_priv (exc_priv),
        .exc_ill  (exc_ill),
`endif
        .int_req  (int_req),
        .int_vec  (int_vec),
        .int_prio (int_prio),
        .pend     (pend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic en, input logic [2:0] pr);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_en   = en;
        cfg_prio = pr;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] vec, input logic [2:0] pr);
        exp_t e;
        e.vec  = vec;
        e.prio = pr;
        sb.push_back(e);
    endtask

    task automatic wait_req(input string tag);
        exp_t e;
        int   cnt = 0;
        while (int_req !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, "_req"}, 32'(int_req), 32'd1);
        check({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_vec"}, 32'(int_vec), 32'(e.vec));
            check({tag, "_prio"}, 32'(int_prio), 32'(e.prio));
        end
    endtask

    task automatic do_ack(input string tag);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check({tag, "_ack_drop"}, 32'(int_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every request line asserted.
        rst = 1'b0;
        irq = 8'hFF;
        step();
        step();
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_vec", 32'(int_vec), 32'd0);
        check("rst_prio", 32'(int_prio), 32'd0);
        irq = 8'h00;
        rst = 1'b1;
        step();
        step();
        check("post_rst_pend", 32'(pend), 32'd0);
        check("post_rst_req", 32'(int_req), 32'd0);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("idle_ack_ignored", 32'(int_req), 32'd0);

        // Single source with explicit latency check.
        cur_prio = 3'd1;
        cfg_write(3, 1'b1, 3'd4);
        irq[3] = 1'b1;
        push_exp(8'h83, 3'd4);
        step();
        irq[3] = 1'b0;
        check("single_pend_set", 32'(pend[3]), 32'd1);
        check("single_req_lat1", 32'(int_req), 32'd0);
        step();
        check("single_req_lat2", 32'(int_req), 32'd1);
        wait_req("single");
        do_ack("single");
        check("single_pend_clr", 32'(pend[3]), 32'd0);

        // Arbitration: highest priority first, then lowest index on ties.
        cfg_write(1, 1'b1, 3'd5);
        cfg_write(2, 1'b1, 3'd5);
        cfg_write(6, 1'b1, 3'd6);
        irq = 8'b0100_0110;
        push_exp(8'h86, 3'd6);
        push_exp(8'h81, 3'd5);
        push_exp(8'h82, 3'd5);
        step();
        irq = 8'h00;
        for (int k = 0; k < 3; k++) begin
            wait_req($sformatf("arb%0d", k));
            do_ack($sformatf("arb%0d", k));
        end

        // Masking by current PSR priority.
        cur_prio = 3'd2;
        cfg_write(0, 1'b1, 3'd2);
        irq[0] = 1'b1;
        step();
        irq[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("mask_no_req", 32'(int_req), 32'd0);
        check("mask_pend", 32'(pend[0]), 32'd1);
        cur_prio = 3'd1;
        push_exp(8'h80, 3'd2);
        wait_req("unmask");
        do_ack("unmask");

        // Hold: no preemption or withdrawal while in REQ; re-edge on ack keeps pend.
        irq[3] = 1'b1;
        push_exp(8'h83, 3'd4);
        step();
        irq[3] = 1'b0;
        wait_req("hold");
        cur_prio = 3'd7;
        cfg_write(3, 1'b0, 3'd4);
        irq[6] = 1'b1;
        step();
        irq[6] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_req", 32'(int_req), 32'd1);
            check("hold_vec", 32'(int_vec), 32'h83);
            check("hold_prio", 32'(int_prio), 32'd4);
        end
        push_exp(8'h86, 3'd6);
        cur_prio = 3'd1;
        irq[3] = 1'b1;
        do_ack("hold");
        irq[3] = 1'b0;
        check("hold_reedge_pend", 32'(pend[3]), 32'd1);
        wait_req("follow");
        do_ack("follow");

`ifdef LC3_INTC_EXC_EN
        // Exceptions beat IRQs; exception priority is the sampled cur_prio.
        cfg_write(5, 1'b1, 3'd3);
        exc_ill = 1'b1;
        irq[5]  = 1'b1;
        push_exp(8'h01, 3'd1);
        push_exp(8'h85, 3'd3);
        step();
        exc_ill = 1'b0;
        irq[5]  = 1'b0;
        wait_req("exc_ill");
        do_ack("exc_ill");
        wait_req("exc_irq5");
        do_ack("exc_irq5");
        cur_prio = 3'd7;
        exc_priv = 1'b1;
        push_exp(8'h00, 3'd7);
        step();
        exc_priv = 1'b0;
        wait_req("exc_priv");
        do_ack("exc_priv");
        cur_prio = 3'd1;
`endif

        // Reset in the middle of a request drops it without an ack.
        irq[1] = 1'b1;
        push_exp(8'h81, 3'd5);
        step();
        irq[1] = 1'b0;
        wait_req("midrst");
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_req", 32'(int_req), 32'd0);
        check("midrst_vec", 32'(int_vec), 32'd0);
        check("midrst_pend", 32'(pend), 32'd0);
        step();
        step();
        check("midrst_stays_idle", 32'(int_req), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
